// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
package seven_segment_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic {BLANK = 1'b0, ON = 1'b1} scan_state_t;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_SLOT_CYCLES  = 12000;
    localparam int DEF_BLANK_CYCLES = 600;

endpackage

// File: rtl/slot_timer.sv
// Slot counter, blank/on state machine and digit index for the scanner.
module slot_timer
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int CW = $clog2(SLOT_CYCLES),
    localparam int IW = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] index,
    output logic          on_window,
    output logic          slot_end,
    output logic          frame_end
);

    logic [CW-1:0] cnt;
    scan_state_t   state, state_nx;

    assign slot_end  = (cnt == CW'(SLOT_CYCLES - 1));
    assign frame_end = slot_end && (index == IW'(NUM_DIGITS - 1));
    assign on_window = (state == ON);

    // State tracks cnt: ON exactly while cnt >= BLANK_CYCLES.
    always_comb begin
        state_nx = state;
        if (slot_end)
            state_nx = BLANK;
        else if (cnt == CW'(BLANK_CYCLES - 1))
            state_nx = ON;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            index <= '0;
            state <= BLANK;
        end else begin
            state <= state_nx;
            cnt   <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                index <= frame_end ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed 7-segment scanner with dead time and frame-aligned loads.
// SEVEN_SEGMENT_SCAN_LZB_EN enables leading-zero blanking.
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [3:0]              digit_bin,
    input  logic [7:0]              seg_in,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);

    logic [IW-1:0]           index;
    logic                    on_window, slot_end, frame_end;
    logic [4*NUM_DIGITS-1:0] active_val, shadow_val;
    logic [NUM_DIGITS-1:0]   active_dp, shadow_dp;
    logic                    pending;
    logic [7:0]              seg_nx;
    logic [NUM_DIGITS-1:0]   sel_nx;
    logic                    dp_cur;

    slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .index    (index),
        .on_window(on_window),
        .slot_end (slot_end),
        .frame_end(frame_end)
    );

    // Driven during blank too, so the external decoder has settled by ON.
    assign digit_bin = active_val[4*index +: 4];
    assign dp_cur    = active_dp[index];

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above & (active_val[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above;
        end
    end
`endif

    always_comb begin
        seg_nx = '0;
        sel_nx = '0;
        if (on_window) begin
            sel_nx = NUM_DIGITS'(1) << index;
            seg_nx = {seg_in[SEG_A:SEG_G], dp_cur};
`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
            if (lz_blank[index])
                seg_nx = {7'b0, dp_cur};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg         <= '0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
            active_val  <= '0;
            active_dp   <= '0;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
        end else begin
            seg         <= seg_nx;
            digit_sel   <= sel_nx;
            frame_start <= frame_end;
            if (frame_end && pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
                pending    <= 1'b0;
            end
            // A load on the boundary cycle lands in shadow and waits a frame.
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_mask;
                pending    <= 1'b1;
            end
        end
    end

endmodule
